// File: rtl/demux1x8_deser_pkg.sv
// Shared constants and types for the 1:N serial-to-parallel demultiplexer.
package demux1x8_deser_pkg;

    // Default frame width and the matching slot index width.
    localparam int N_DEFAULT     = 8;
    localparam int SEL_W_DEFAULT = $clog2(N_DEFAULT);

    // Slot index and assembled frame at the default width.
    typedef logic [SEL_W_DEFAULT-1:0] slot_t;
    typedef logic [N_DEFAULT-1:0]     frame_t;

endpackage : demux1x8_deser_pkg

// File: rtl/demux1x8_deser_if.sv
// Serial input, slot control and parallel frame handshake of the deserializer.
// The block itself uses the slave modport; whoever feeds it uses master.
interface demux1x8_deser_if
    import demux1x8_deser_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int SEL_W = $clog2(N);

    // Serial side
    logic             din;
    logic             din_valid;
    logic             din_ready;
    // Slot pointer control and visibility
    logic             sel_load;
    logic [SEL_W-1:0] sel_in;
    logic [SEL_W-1:0] slot;
    // Parallel frame side
    logic [N-1:0]     out;
    logic [N-1:0]     out_mask;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output din, din_valid, sel_load, sel_in, out_ready,
        input  din_ready, slot, out, out_mask, out_valid
    );

    modport slave (
        input  din, din_valid, sel_load, sel_in, out_ready,
        output din_ready, slot, out, out_mask, out_valid
    );

endinterface : demux1x8_deser_if

// File: rtl/demux1x8_deser_slot_counter.sv
// Modulo-N slot pointer with load priority over increment. Also exposes the
// index in effect this cycle (load value when loading, else the pointer), so a
// serializer or deserializer can address its current bit without duplicating
// the load/increment rule.
module demux1x8_deser_slot_counter #(
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             inc,
    output logic [SEL_W-1:0] idx,
    output logic [SEL_W-1:0] slot
);

    logic [SEL_W-1:0] slot_q;
    logic [SEL_W-1:0] slot_d;
    logic [SEL_W-1:0] base;

    // Effective index for this cycle and the next pointer value. N is a power
    // of two, so the natural SEL_W-bit overflow provides the N-1 -> 0 wrap.
    always_comb begin
        base   = load ? load_val : slot_q;
        slot_d = inc ? base + 1'b1 : base;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign idx  = base;
    assign slot = slot_q;

endmodule : demux1x8_deser_slot_counter

// File: rtl/demux1x8_deser.sv
// Registered 1:N demultiplexer / deserializer. Serial bits are steered into a
// shadow frame at the current slot; the bit landing in slot N-1 completes the
// frame, which moves to the output register behind a valid/ready handshake.
// Only the completing bit stalls while an earlier frame is still unconsumed.
module demux1x8_deser
    import demux1x8_deser_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    demux1x8_deser_if.slave  bus
);

    logic [SEL_W-1:0] w;
    logic [SEL_W-1:0] slot;
    logic             last_slot;
    logic             din_ready;
    logic             accept;
    logic [N-1:0]     wr_oh;
    logic [N-1:0]     shadow_merged;
    logic [N-1:0]     mask_merged;

    logic [N-1:0]     shadow_q,      shadow_d;
    logic [N-1:0]     shadow_mask_q, shadow_mask_d;
    logic [N-1:0]     out_q,         out_d;
    logic [N-1:0]     out_mask_q,    out_mask_d;
    logic             out_valid_q,   out_valid_d;
    logic             ready_en_q,    ready_en_d;

    demux1x8_deser_slot_counter #(.N(N)) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.sel_load),
        .load_val (bus.sel_in),
        .inc      (accept),
        .idx      (w),
        .slot     (slot)
    );

    // One-hot decode of the write index.
    for (genvar gi = 0; gi < N; gi++) begin : g_wr_dec
        assign wr_oh[gi] = (w == SEL_W'(gi));
    end

    assign last_slot = (w == SEL_W'(N - 1));

    // ready_en_q holds din_ready low through reset and the cycle of release.
    assign din_ready = ready_en_q && !(out_valid_q && !bus.out_ready && last_slot);
    assign accept    = bus.din_valid && din_ready;

    // Current shadow contents with the incoming bit dropped into slot w.
    assign shadow_merged = (shadow_q & ~wr_oh) | ({N{bus.din}} & wr_oh);
    assign mask_merged   = shadow_mask_q | wr_oh;

    // Next-state for the shadow frame, the output frame and the handshake.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_mask_d = shadow_mask_q;
        out_d         = out_q;
        out_mask_d    = out_mask_q;
        out_valid_d   = out_valid_q && !bus.out_ready;
        ready_en_d    = 1'b1;
        if (accept) begin
            if (last_slot) begin
                // A completing accept may coincide with consumption of the
                // previous frame; the new frame simply replaces it.
                out_d         = shadow_merged;
                out_mask_d    = mask_merged;
                out_valid_d   = 1'b1;
                shadow_d      = '0;
                shadow_mask_d = '0;
            end else begin
                shadow_d      = shadow_merged;
                shadow_mask_d = mask_merged;
            end
        end
    end

    // Frame and handshake registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            shadow_mask_q <= '0;
            out_q         <= '0;
            out_mask_q    <= '0;
            out_valid_q   <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_mask_q <= shadow_mask_d;
            out_q         <= out_d;
            out_mask_q    <= out_mask_d;
            out_valid_q   <= out_valid_d;
            ready_en_q    <= ready_en_d;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.slot      = slot;
    assign bus.out       = out_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_valid = out_valid_q;

endmodule : demux1x8_deser

// File: tb/tb_demux1x8_deser.sv
// Self-checking bench for demux1x8_deser: directed scenarios plus a random
// phase, all compared every cycle against a slot-array reference model.
module tb_demux1x8_deser;
    import demux1x8_deser_pkg::*;

    localparam int N     = N_DEFAULT;
    localparam int SEL_W = SEL_W_DEFAULT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    demux1x8_deser_if #(.N(N)) bus ();

    demux1x8_deser #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: one entry per slot, frame built from the slot array.
    int     m_slot;
    bit     m_sh  [N];
    bit     m_shm [N];
    frame_t m_out;
    frame_t m_mask;
    bit     m_valid;
    bit     m_rdy_en;
    int     frames_done;
    int     stall_cycles;
    bit     obs_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_slot   = 0;
        m_out    = '0;
        m_mask   = '0;
        m_valid  = 1'b0;
        m_rdy_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = 1'b0;
            m_shm[i] = 1'b0;
        end
    endfunction

    function automatic bit model_ready(input bit sl, input int si, input bit ordy);
        int widx;
        widx = sl ? si : m_slot;
        return m_rdy_en && !(m_valid && !ordy && widx == N - 1);
    endfunction

    function automatic void model_edge(input bit d, input bit dv, input bit sl,
                                       input int si, input bit ordy, input bit rdy);
        int  widx;
        bit  acc;
        widx = sl ? si : m_slot;
        acc  = dv && rdy;
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            m_sh[widx]  = d;
            m_shm[widx] = 1'b1;
            if (widx == N - 1) begin
                for (int i = 0; i < N; i++) begin
                    m_out[i]  = m_sh[i];
                    m_mask[i] = m_shm[i];
                    m_sh[i]   = 1'b0;
                    m_shm[i]  = 1'b0;
                end
                m_valid = 1'b1;
                frames_done++;
                $display("frame %0d: out=%02h mask=%02h", frames_done, m_out, m_mask);
            end
        end
        if (sl) m_slot = (si + (acc ? 1 : 0)) % N;
        else if (acc) m_slot = (m_slot + 1) % N;
        m_rdy_en = 1'b1;
    endfunction

    // One clock: drive at the falling edge, compare, then advance the model.
    task automatic cycle(input bit d, input bit dv, input bit sl, input int si, input bit ordy);
        bit er;
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = dv;
        bus.sel_load  = sl;
        bus.sel_in    = si[SEL_W-1:0];
        bus.out_ready = ordy;
        #1;
        er      = model_ready(sl, si, ordy);
        obs_rdy = bus.din_ready;
        check("din_ready", bus.din_ready, er);
        check("slot", bus.slot, m_slot);
        check("out", bus.out, m_out);
        check("out_mask", bus.out_mask, m_mask);
        check("out_valid", bus.out_valid, m_valid);
        if (dv && !er) stall_cycles++;
        @(posedge clk);
        model_edge(d, dv, sl, si, ordy, er);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_at_release", bus.din_ready, 1'b0);
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        bit bits1 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int f0, s0;

        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sel_load = 1'b0;
        bus.sel_in = '0; bus.out_ready = 1'b0;
        frames_done = 0; stall_cycles = 0;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        check("rst_out", bus.out, 0);
        check("rst_mask", bus.out_mask, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_slot", bus.slot, 0);
        check("rst_ready", bus.din_ready, 0);
        release_reset();

        // Basic frame 1,0,1,1,0,0,1,0 with consumer always ready
        for (int i = 0; i < 8; i++) cycle(bits1[i], 1'b1, 1'b0, 0, 1'b1);
        #2;
        check("tp1_out", bus.out, 8'h4D);
        check("tp1_mask", bus.out_mask, 8'hFF);
        check("tp1_valid", bus.out_valid, 1'b1);
        check("tp1_slot", bus.slot, 0);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
        #2;
        check("tp1_valid_pulse", bus.out_valid, 1'b0);

        // Backpressure: only the completing bit stalls
        for (int i = 0; i < 8; i++) cycle(1'($urandom), 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'($urandom), 1'b1, 1'b0, 0, 1'b0);
            check("tp2_ready_mid", obs_rdy, 1'b1);
        end
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check("tp2_stall", obs_rdy, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        check("tp2_release", obs_rdy, 1'b1);
        #2;
        check("tp2_valid_kept", bus.out_valid, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Load slot 5 together with an accept, then two more bits
        cycle(1'b1, 1'b1, 1'b1, 5, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        #2;
        check("tp3_out", bus.out, 8'hE0);
        check("tp3_mask", bus.out_mask, 8'hE0);

        // Load without data, then fill slots 3..7
        cycle(1'b0, 1'b0, 1'b1, 3, 1'b1);
        #2;
        check("tp4_slot", bus.slot, 3);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        #2;
        check("tp4_slot_inc", bus.slot, 4);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1);
        #2;
        check("tp4_out", bus.out, 8'hD8);
        check("tp4_mask", bus.out_mask, 8'hF8);

        // Asynchronous reset mid-frame with a pending output frame
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        bus.din_valid = 1'b0; bus.sel_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("tp5_valid", bus.out_valid, 0);
        check("tp5_out", bus.out, 0);
        check("tp5_mask", bus.out_mask, 0);
        check("tp5_slot", bus.slot, 0);
        model_reset();
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 0, 1'b1);
        #2;
        check("tp5_new_out", bus.out, 8'h00);
        check("tp5_new_mask", bus.out_mask, 8'hFF);

        // Continuous 24-bit stream: three frames, no stalls
        f0 = frames_done; s0 = stall_cycles;
        for (int i = 0; i < 24; i++) cycle(1'($urandom), 1'b1, 1'b0, 0, 1'b1);
        check("tp6_frames", frames_done - f0, 3);
        check("tp6_stalls", stall_cycles - s0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, N - 1)), 1'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux1x8_deser
